// File: rtl/bd_downstream_decoder.sv
// Decodes host words from the PipeIn FIFO into BD reset/hold control and BD output words.
// A single output register carries BD words; every opcode is stalled while that word waits.
module bd_downstream_decoder #(
  parameter int IN_WIDTH   = 32,
  parameter int BD_WIDTH   = 21,
  parameter int CODE_WIDTH = 6,
  parameter int CNT_WIDTH  = 16,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BD_WIDTH-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  pReset,
  output logic                  sReset,
  output logic                  hold_en,
  output logic [CNT_WIDTH-1:0]  sent_count,
  output logic [ERR_WIDTH-1:0]  err_count
);

  localparam logic [CODE_WIDTH-1:0] OP_SEND     = CODE_WIDTH'(6'b010000);
  localparam logic [CODE_WIDTH-1:0] OP_PRESET   = CODE_WIDTH'(6'b001000);
  localparam logic [CODE_WIDTH-1:0] OP_SRESET   = CODE_WIDTH'(6'b000100);
  localparam logic [CODE_WIDTH-1:0] OP_HOLD_ON  = CODE_WIDTH'(6'b000010);
  localparam logic [CODE_WIDTH-1:0] OP_HOLD_OFF = CODE_WIDTH'(6'b000001);

  logic [CODE_WIDTH-1:0] op;
  logic [BD_WIDTH-1:0]   hold_data;
  logic                  accept;
  logic                  handoff;
  logic                  unused_bits;

  assign op          = in_data[IN_WIDTH-1 -: CODE_WIDTH];
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign handoff     = out_valid && out_ready;
  // Bits between the opcode and the BD payload carry no meaning.
  assign unused_bits = ^in_data[IN_WIDTH-CODE_WIDTH-1:BD_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pReset     <= 1'b1;
      sReset     <= 1'b1;
      hold_en    <= 1'b0;
      hold_data  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      sent_count <= '0;
      err_count  <= '0;
    end else begin
      if (handoff) begin
        out_valid  <= 1'b0;
        sent_count <= sent_count + CNT_WIDTH'(1);
      end
      // The MSB marks a NOP and wins over every other opcode pattern.
      if (accept && !op[CODE_WIDTH-1]) begin
        case (op)
          OP_SEND: begin
            out_data  <= hold_en ? hold_data : in_data[BD_WIDTH-1:0];
            out_valid <= 1'b1;
          end
          OP_PRESET:   pReset <= in_data[0];
          OP_SRESET:   sReset <= in_data[0];
          OP_HOLD_ON: begin
            hold_data <= in_data[BD_WIDTH-1:0];
            hold_en   <= 1'b1;
          end
          OP_HOLD_OFF: hold_en <= 1'b0;
          default: begin
            if (err_count != '1) err_count <= err_count + ERR_WIDTH'(1);
          end
        endcase
      end
    end
  end

endmodule
